bounded_up_down_counter: RTL and testbench

- Parametrised successor of the 4-bit up/down counter.
- Counts up or down between runtime-programmable bounds [min_val, max_val].
- Selectable wrap or saturate mode, with synchronous parallel load and count enable.
- Outputs terminal-count flags and a registered wrap/saturation event pulse.
- Used as a general-purpose sequencer/timer element wherever the fixed 0..2^SIZE-1 free-running counter is insufficient.

---
 rtl/bounded_up_down_counter.sv | 98 +++++++++
 tb/tb_bounded_up_down_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bounded_up_down_counter.sv
// Up/down counter confined to runtime-programmable bounds [min_val, max_val].
// Supports wrap or saturate at the bounds, clamped parallel load and registered event pulses.
module bounded_up_down_counter #(
    parameter int unsigned     SIZE    = 4,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            up_down,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic [SIZE-1:0] min_val,
    input  logic [SIZE-1:0] max_val,
    input  logic            sat_mode,
    output logic [SIZE-1:0] count,
    output logic            at_max,
    output logic            at_min,
    output logic            wrap_evt,
    output logic            sat_evt,
    output logic            cfg_err
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    logic [SIZE-1:0] count_reg;
    logic [SIZE-1:0] count_next;
    logic            wrap_evt_reg;
    logic            wrap_evt_next;
    logic            sat_evt_reg;
    logic            sat_evt_next;

    assign cfg_err  = (min_val > max_val);
    assign count    = count_reg;
    assign at_max   = (count_reg == max_val);
    assign at_min   = (count_reg == min_val);
    assign wrap_evt = wrap_evt_reg;
    assign sat_evt  = sat_evt_reg;

    // Bounds are compared before stepping, so the +1/-1 never needs a carry bit.
    always_comb begin
        count_next    = count_reg;
        wrap_evt_next = 1'b0;
        sat_evt_next  = 1'b0;
        if (cfg_err) begin
            count_next = count_reg;
        end else if (load) begin
            if (load_val < min_val) begin
                count_next = min_val;
            end else if (load_val > max_val) begin
                count_next = max_val;
            end else begin
                count_next = load_val;
            end
        end else if (en) begin
            if (count_reg > max_val) begin
                count_next = max_val;
            end else if (count_reg < min_val) begin
                count_next = min_val;
            end else if (up_down) begin
                if (count_reg == max_val) begin
                    if (sat_mode) begin
                        sat_evt_next = 1'b1;
                    end else begin
                        count_next    = min_val;
                        wrap_evt_next = 1'b1;
                    end
                end else begin
                    count_next = count_reg + ONE;
                end
            end else begin
                if (count_reg == min_val) begin
                    if (sat_mode) begin
                        sat_evt_next = 1'b1;
                    end else begin
                        count_next    = max_val;
                        wrap_evt_next = 1'b1;
                    end
                end else begin
                    count_next = count_reg - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= RST_VAL;
            wrap_evt_reg <= 1'b0;
            sat_evt_reg  <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wrap_evt_reg <= wrap_evt_next;
            sat_evt_reg  <= sat_evt_next;
        end
    end

endmodule

// File: tb/tb_bounded_up_down_counter.sv
// Scoreboard bench: the driver pushes model predictions, a monitor pops and compares after each edge.
module tb_bounded_up_down_counter;

    localparam int SIZE    = 4;
    localparam int RST_INT = 0;

    logic            clk;
    logic            rst;
    logic            en;
    logic            up_down;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic [SIZE-1:0] min_val;
    logic [SIZE-1:0] max_val;
    logic            sat_mode;
    logic [SIZE-1:0] count;
    logic            at_max;
    logic            at_min;
    logic            wrap_evt;
    logic            sat_evt;
    logic            cfg_err;

    bounded_up_down_counter #(
        .SIZE    (SIZE),
        .RST_VAL (4'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .min_val  (min_val),
        .max_val  (max_val),
        .sat_mode (sat_mode),
        .count    (count),
        .at_max   (at_max),
        .at_min   (at_min),
        .wrap_evt (wrap_evt),
        .sat_evt  (sat_evt),
        .cfg_err  (cfg_err)
    );

    typedef struct {
        int cnt;
        int wrap;
        int sat;
        int amax;
        int amin;
        int cerr;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    int   m_count  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %0d, required %0d", name, n_txn, act, req);
        end
    endtask

    // Reference model: take the step with plain integer arithmetic, then fold it back at the bounds.
    task automatic step(input bit r, input bit e, input bit ud, input bit ld,
                        input int lv, input int mn, input int mx, input bit sm);
        int nxt;
        int w;
        int s;
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        up_down  = ud;
        load     = ld;
        load_val = lv[SIZE-1:0];
        min_val  = mn[SIZE-1:0];
        max_val  = mx[SIZE-1:0];
        sat_mode = sm;
        w   = 0;
        s   = 0;
        nxt = m_count;
        if (r) begin
            nxt = RST_INT;
        end else if (mn > mx) begin
            nxt = m_count;
        end else if (ld) begin
            nxt = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
        end else if (e) begin
            if (m_count > mx) begin
                nxt = mx;
            end else if (m_count < mn) begin
                nxt = mn;
            end else begin
                nxt = ud ? m_count + 1 : m_count - 1;
                if (nxt > mx || nxt < mn) begin
                    if (sm) begin
                        nxt = m_count;
                        s   = 1;
                    end else begin
                        nxt = ud ? mn : mx;
                        w   = 1;
                    end
                end
            end
        end
        m_count = nxt;
        x.cnt  = nxt;
        x.wrap = w;
        x.sat  = s;
        x.amax = (nxt == mx) ? 1 : 0;
        x.amin = (nxt == mn) ? 1 : 0;
        x.cerr = (mn > mx) ? 1 : 0;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: count=%0d wrap=%0b sat=%0b at_max=%0b at_min=%0b cfg_err=%0b | exp count=%0d",
                         n_txn, count, wrap_evt, sat_evt, at_max, at_min, cfg_err, e.cnt);
                chk("count",    int'(count),    e.cnt);
                chk("wrap_evt", int'(wrap_evt), e.wrap);
                chk("sat_evt",  int'(sat_evt),  e.sat);
                chk("at_max",   int'(at_max),   e.amax);
                chk("at_min",   int'(at_min),   e.amin);
                chk("cfg_err",  int'(cfg_err),  e.cerr);
            end
        end
    end

    initial begin : driver
        int mn;
        int mx;
        int tmp;
        int guard;
        rst = 1'b1; en = 1'b0; up_down = 1'b0; load = 1'b0;
        load_val = '0; min_val = '0; max_val = '1; sat_mode = 1'b0;

        // Legacy free-running behaviour
        repeat (2) step(1, 0, 0, 0, 0, 0, 15, 0);
        repeat (17) step(0, 1, 1, 0, 0, 0, 15, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 15, 0);

        // Wrap downward in [3,9]
        step(0, 0, 0, 1, 5, 3, 9, 0);
        repeat (5) step(0, 1, 0, 0, 0, 3, 9, 0);

        // Saturate upward in [3,9]
        step(0, 0, 0, 1, 7, 3, 9, 1);
        repeat (5) step(0, 1, 1, 0, 0, 3, 9, 1);
        repeat (4) step(0, 1, 0, 0, 0, 3, 4, 1);

        // Clamped loads, with and without enable
        step(0, 1, 1, 1, 12, 3, 9, 0);
        step(0, 1, 1, 1, 1, 3, 9, 0);
        step(0, 0, 0, 1, 6, 3, 9, 0);

        // Runtime bound change pulls count in; then an illegal config freezes it
        step(0, 0, 0, 1, 8, 3, 9, 0);
        step(0, 1, 0, 0, 0, 3, 5, 0);
        step(0, 1, 1, 1, 2, 10, 5, 0);
        step(0, 1, 0, 0, 0, 10, 5, 1);

        // Pinned counter: every enabled step wraps or saturates in place
        step(0, 0, 0, 1, 5, 5, 5, 0);
        repeat (2) step(0, 1, 1, 0, 0, 5, 5, 0);
        repeat (2) step(0, 1, 0, 0, 0, 5, 5, 1);

        // Reset overrides a simultaneous load and enable
        step(1, 1, 1, 1, 7, 3, 9, 0);
        step(0, 0, 0, 0, 0, 3, 9, 0);

        mn = 2;
        mx = 11;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                mn = $urandom_range(0, 15);
                mx = $urandom_range(0, 15);
                if (mn > mx && $urandom_range(0, 9) != 0) begin
                    tmp = mn;
                    mn  = mx;
                    mx  = tmp;
                end
            end
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15),
                 mn, mx,
                 $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
